// File: rtl/imem_stream_loaded.sv
// Instruction memory: NOP-clear sweep, streamed program load, then registered fetch port.
// Optional IMEM_RELOAD_EN adds a reload input that returns RUN to the clear sweep.
module imem_stream_loaded #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef IMEM_RELOAD_EN
  input  logic                         reload,
`endif
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         load_last,
  input  logic                         fetch_en,
  input  logic [ADDR_W-1:0]            fetch_addr,
  output logic [DATA_W-1:0]            instr,
  output logic                         instr_valid,
  output logic                         addr_fault,
  output logic                         loaded,
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                addr_fault_q, addr_fault_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [PTR_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                reload_c;
  logic                xfer_c, load_done_c, clr_done_c;
  logic [ADDR_W-1:0]   idx_c;
  logic                misalign_c, fetch_bad_c;

`ifdef IMEM_RELOAD_EN
  assign reload_c = reload;
`else
  assign reload_c = 1'b0;
`endif

  assign xfer_c      = (state_q == S_LOAD) && load_valid;
  assign load_done_c = xfer_c && (load_last || (wr_ptr_q == PTR_W'(DEPTH - 1)));
  assign clr_done_c  = (state_q == S_CLEAR) && (clr_ptr_q == PTR_W'(DEPTH - 1));

  // Full-width index compare so high PC bits never alias into the array.
  assign idx_c       = (BYTE_ADDR != 0) ? (fetch_addr >> 2) : fetch_addr;
  assign misalign_c  = (BYTE_ADDR != 0) && (fetch_addr[1:0] != 2'b00);
  assign fetch_bad_c = misalign_c || (idx_c >= ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_done_c)  state_d = S_LOAD;
      S_LOAD:  if (load_done_c) state_d = S_RUN;
      S_RUN:   if (reload_c)    state_d = S_CLEAR;
      default:                  state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    clr_ptr_d     = clr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    word_count_d  = word_count_q;
    instr_d       = NOP_WORD;
    instr_valid_d = 1'b0;
    addr_fault_d  = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = clr_ptr_q;
    mem_wdata     = NOP_WORD;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_done_c ? '0 : clr_ptr_q + PTR_W'(1);
      end
      S_LOAD: begin
        if (xfer_c) begin
          mem_we       = 1'b1;
          mem_waddr    = wr_ptr_q;
          mem_wdata    = load_data;
          wr_ptr_d     = wr_ptr_q + PTR_W'(1);
          word_count_d = word_count_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (reload_c) begin
          clr_ptr_d    = '0;
          wr_ptr_d     = '0;
          word_count_d = '0;
        end else if (fetch_en) begin
          instr_valid_d = 1'b1;
          addr_fault_d  = fetch_bad_c;
          instr_d       = fetch_bad_c ? NOP_WORD : mem_q[idx_c[PTR_W-1:0]];
        end else begin
          instr_d       = instr_q;
          instr_valid_d = instr_valid_q;
          addr_fault_d  = addr_fault_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      word_count_q  <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_fault_q  <= 1'b0;
    end else begin
      clr_ptr_q     <= clr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      word_count_q  <= word_count_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_fault_q  <= addr_fault_d;
    end
  end

  // Single write port shared by the clear sweep and the loader.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign load_ready  = (state_q == S_LOAD);
  assign loaded      = (state_q == S_RUN);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_fault  = addr_fault_q;
  assign word_count  = word_count_q;

endmodule
